pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_fetch_sequencer.sv | 116 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer for the MiniCPU front end.
// Fetches from imem over req/ack, hands instructions to decode over valid/ready.
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   pc_sel,
  output logic                   halted,
  output logic [15:0]            instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   pc_sel_q, pc_sel_d;
  logic [15:0]            count_q, count_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= {INSTR_WIDTH{1'b0}};
      pc_sel_q <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_sel_q <= pc_sel_d;
      count_q  <= count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_sel_d = pc_sel_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
          // halt wins over branch; a halting instruction leaves pc/pc_sel as-is
          if (halt) begin
            state_d = ST_HALTED;
          end else if (branch_taken) begin
            pc_d     = branch_target;
            pc_sel_d = 1'b1;
            state_d  = ST_REQ;
          end else begin
            pc_d     = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            pc_sel_d = 1'b0;
            state_d  = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_REQ);
  assign instr_valid = (state_q == ST_HOLD);
  assign halted      = (state_q == ST_HALTED);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign pc_sel      = pc_sel_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus random
// traffic compared against a transaction-level model of the fetch loop.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halt;
  logic [7:0]  pc;
  logic        pc_sel;
  logic        halted;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what the sequencer has done so far, not how it encodes it
  bit          m_started;
  bit          m_have;
  bit          m_halted;
  logic [7:0]  m_pc;
  logic        m_sel;
  logic [15:0] m_instr;
  int          m_cnt;

  pc_fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .pc(pc), .pc_sel(pc_sel), .halted(halted), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_have    = 1'b0;
    m_halted  = 1'b0;
    m_pc      = 8'h00;
    m_sel     = 1'b0;
    m_instr   = 16'h0000;
    m_cnt     = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".req"},   32'(imem_req),    32'(m_started && !m_have && !m_halted));
    check_eq({tag, ".addr"},  32'(imem_addr),   32'(m_pc));
    check_eq({tag, ".pc"},    32'(pc),          32'(m_pc));
    check_eq({tag, ".valid"}, 32'(instr_valid), 32'(m_have && !m_halted));
    check_eq({tag, ".instr"}, 32'(instr),       32'(m_instr));
    check_eq({tag, ".sel"},   32'(pc_sel),      32'(m_sel));
    check_eq({tag, ".halted"},32'(halted),      32'(m_halted));
    check_eq({tag, ".count"}, 32'(instr_count), 32'(m_cnt));
  endtask

  // One clock: apply inputs at the falling edge, advance the model at the
  // rising edge, then compare at the next falling edge.
  task automatic cycle(input string tag, input bit ack, input logic [15:0] data,
                       input bit rdy, input bit br, input logic [7:0] tgt, input bit hlt);
    imem_ack = ack; imem_data = data; instr_ready = rdy;
    branch_taken = br; branch_target = tgt; halt = hlt;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (!m_have) begin
      if (ack) begin
        m_instr = data;
        m_have  = 1'b1;
      end
    end else if (rdy) begin
      if (m_cnt < 65535) m_cnt++;
      if (hlt) begin
        m_halted = 1'b1;
      end else begin
        m_pc   = br ? tgt : 8'((m_pc + 1) % 256);
        m_sel  = br;
        m_have = 1'b0;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("idle");
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00; halt = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_eq("t1.idle_req", 32'(imem_req), 32'd0);

    // Fetch with wait states and backpressure
    cycle("t2.req0", 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("t2.req_addr", {imem_req, 23'd0, imem_addr}, {1'b1, 31'h00});
    cycle("t2.wait1", 1'b0, 16'h1111, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t2.ack",   1'b1, 16'hA5A5, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("t2.instr", 32'(instr), 32'h0000A5A5);
    for (int i = 0; i < 3; i++) cycle("t2.stall", 1'b1, 16'h5A5A, 1'b0, 1'b1, 8'h99, 1'b0);
    cycle("t2.accept", 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("t2.next", {imem_req, pc_sel, 6'd0, imem_addr, instr_count}, {1'b1, 1'b0, 6'd0, 8'h01, 16'd1});

    // Branch then sequential
    cycle("t3.ack", 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t3.br",  1'b0, 16'h0000, 1'b1, 1'b1, 8'h40, 1'b0);
    check_eq("t3.br_addr", {pc_sel, 23'd0, imem_addr}, {1'b1, 23'd0, 8'h40});
    cycle("t3.ack2", 1'b1, 16'h2345, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t3.seq",  1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("t3.seq_addr", {pc_sel, 23'd0, imem_addr}, {1'b0, 23'd0, 8'h41});

    // Wrap at 0xFF
    cycle("t4.ack", 1'b1, 16'h3456, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t4.br",  1'b0, 16'h0000, 1'b1, 1'b1, 8'hFF, 1'b0);
    cycle("t4.ack2", 1'b1, 16'h4567, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t4.wrap", 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("t4.wrap_pc", {pc, imem_addr}, 16'h0000);

    // Halt beats branch; halted ignores ack traffic
    cycle("t5.ack", 1'b1, 16'h5678, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t5.halt", 1'b0, 16'h0000, 1'b1, 1'b1, 8'h77, 1'b1);
    check_eq("t5.halted", {halted, 23'd0, pc}, {1'b1, 23'd0, 8'h00});
    for (int i = 0; i < 20; i++) begin
      cycle("t5.idle", 1'(i % 2), 16'(i * 7), 1'b1, 1'b1, 8'h10, 1'b0);
      check_eq("t5.noreq", 32'(imem_req), 32'd0);
    end
    do_reset();
    cycle("t5.resume", 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("t5.resume_addr", {imem_req, 23'd0, imem_addr}, {1'b1, 31'h00});

    // Async reset mid-REQ after moving pc away from zero
    cycle("t6.ack", 1'b1, 16'h6789, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle("t6.br",  1'b0, 16'h0000, 1'b1, 1'b1, 8'h5C, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6.async", {imem_req, 23'd0, pc}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("t6.rel");
    cycle("t6.spur_idle", 1'b0, 16'h0000, 1'b1, 1'b1, 8'h33, 1'b1);
    cycle("t6.spur_req",  1'b0, 16'h0000, 1'b1, 1'b1, 8'h33, 1'b1);
    check_eq("t6.spur_pc", 32'(pc), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        do_reset();
      end else begin
        cycle("rnd", 1'($urandom_range(0, 2) != 0), 16'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
              8'($urandom), 1'($urandom_range(0, 40) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
